hilo_result_unit: RTL

- Downstream consumer of the sequential Booth multiplier and of the divider in the datapath.
- Accepts each 2*WORD-bit product, or each quotient/remainder pair, over a valid/ready handshake and commits it to the architectural HI/LO registers.
- Serves mfhi/mflo-style reads and mthi/mtlo-style writes.
- Tracks multiply/divide operations in flight and interlocks reads and writes until HI/LO are up to date.

---
 rtl/hilo_if.sv | 29 ++
 rtl/hilo_result_unit.sv | 47 ++++
 2 files changed

// File: rtl/hilo_if.sv
// hilo_if: result/issue/move/read bundle between the datapath and the HI/LO result unit.
interface hilo_if #(parameter int WORD = 32);
    logic            issue, issue_ready;
    logic            mul_valid, mul_ready;
    logic [2*WORD-1:0] mul_prod;
    logic            div_valid, div_ready;
    logic [WORD-1:0] div_quot, div_rem;
    logic            mt_hi, mt_lo;
    logic [WORD-1:0] mt_data;
    logic            rd_hi, rd_lo;
    logic [WORD-1:0] rd_data;
    logic            rd_valid, stall;
    logic [WORD-1:0] hi, lo;
    logic [1:0]      pend;
    logic            err;

    modport master (
        output issue, mul_valid, mul_prod, div_valid, div_quot, div_rem,
               mt_hi, mt_lo, mt_data, rd_hi, rd_lo,
        input  issue_ready, mul_ready, div_ready, rd_data, rd_valid, stall,
               hi, lo, pend, err
    );
    modport slave (
        input  issue, mul_valid, mul_prod, div_valid, div_quot, div_rem,
               mt_hi, mt_lo, mt_data, rd_hi, rd_lo,
        output issue_ready, mul_ready, div_ready, rd_data, rd_valid, stall,
               hi, lo, pend, err
    );
endinterface

// File: rtl/hilo_result_unit.sv
// hilo_result_unit: commits mul/div results to HI/LO, serves mf/mt accesses, interlocks on in-flight ops.
module hilo_result_unit #(
    parameter int WORD     = 32,
    parameter int MAX_PEND = 2
) (
    input logic   clk,
    input logic   clr,
    hilo_if.slave bus
);
    logic idle, retire, take;

    assign idle            = bus.pend == 2'd0;
    assign bus.mul_ready   = bus.mul_valid & ~idle;
    assign bus.div_ready   = bus.div_valid & ~idle & ~bus.mul_valid;
    assign retire          = bus.mul_ready | bus.div_ready;
    assign bus.issue_ready = (bus.pend < 2'(MAX_PEND)) | retire;
    assign take            = bus.issue & bus.issue_ready;
    assign bus.stall       = (bus.mt_hi | bus.mt_lo | bus.rd_hi | bus.rd_lo) & ~idle;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bus.hi       <= '0;
            bus.lo       <= '0;
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
            bus.pend     <= 2'd0;
            bus.err      <= 1'b0;
        end else begin
            bus.pend     <= bus.pend + 2'(take) - 2'(retire);
            bus.err      <= bus.err | ((bus.mul_valid | bus.div_valid) & idle);
            bus.rd_valid <= (bus.rd_hi | bus.rd_lo) & idle;
            // reads sample the pre-edge registers, so a same-cycle move-to is not visible
            if ((bus.rd_hi | bus.rd_lo) & idle)
                bus.rd_data <= bus.rd_hi ? bus.hi : bus.lo;
            if (bus.mul_ready) begin
                bus.hi <= bus.mul_prod[2*WORD-1:WORD];
                bus.lo <= bus.mul_prod[WORD-1:0];
            end else if (bus.div_ready) begin
                bus.hi <= bus.div_rem;
                bus.lo <= bus.div_quot;
            end else if (idle) begin
                if (bus.mt_hi) bus.hi <= bus.mt_data;
                if (bus.mt_lo) bus.lo <= bus.mt_data;
            end
        end
    end
endmodule
